i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
Write-only I2C target (slave) that receives the codec-configuration frames produced by the team's I2C initiator: address byte, then register byte, then data byte. It decodes the 7-bit register and 9-bit data word and raises a one-cycle write strobe toward a codec register model or shadow register file. It acknowledges only its own write address and drives SDAT open-drain. It is used as an on-chip loopback target and as a bench responder for initiator verification.

Parameters:
DEV_ADDR, 7'h1A, 7-bit device address this target acknowledges.
FILTER_LEN, 3, clk cycles a synchronized SDCLK/SDAT level must be stable before it is accepted (glitch filter), range 1..15.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  reset, asynchronous, active-low.
SDCLK  input  1  I2C clock from the initiator.
SDAT  inout  1  I2C data; the target only ever drives 0 or z.
wr_valid  output  1  one-cycle pulse; a complete write frame was accepted.
wr_reg  output  7  register address; valid when wr_valid=1, held until the next strobe.
wr_data  output  9  data word; valid when wr_valid=1, held until the next strobe.
busy  output  1  high from an accepted START until STOP or abort.
error  output  2  sticky flags: [0]=extra byte received (overrun); [1]=STOP/START arrived mid-frame. Cleared only by reset.

Behaviour:
- Reset (rst=0, async): state IDLE; SDAT released (z) immediately; wr_valid=0, wr_reg=0, wr_data=0, busy=0, error=0; filters preset to 1.
- Input path: 2-flop synchronizer per line, then a FILTER_LEN stability filter. All edges are detected on the filtered levels (scl_f, sda_f).
- START = sda_f falls while scl_f=1. STOP = sda_f rises while scl_f=1. Both take priority over bit sampling in every state.
- Bit sampling: SDAT is sampled on the scl_f rising edge, MSB first, into an 8-bit shift register with a 4-bit bit counter.
- States:
  IDLE: on START -> ADDR, busy=1.
  ADDR: after 8 bits, if byte[7:1]==DEV_ADDR and byte[0]==0 (write) -> ACK_A; otherwise -> IGNORE (no ACK driven).
  ACK_A / ACK_1 / ACK_2: on the scl_f falling edge after the 8th bit, drive SDAT=0. Hold it through the 9th clock high phase. Release on the next scl_f falling edge, then go to BYTE1 / BYTE2 / WAIT_STOP respectively.
  BYTE1: 8 bits; byte[7:1] -> reg_shadow, byte[0] -> data_shadow[8]; -> ACK_1.
  BYTE2: 8 bits -> data_shadow[7:0]; -> ACK_2. One clk after the 8th bit is sampled: wr_valid=1 for exactly one clk, with wr_reg and wr_data loaded together.
  WAIT_STOP: further bits are not ACKed; a completed 9th byte sets error[0]. STOP -> IDLE.
  IGNORE: SDAT released; wait for STOP -> IDLE, or START -> ADDR.
- Mid-frame events:
  - STOP in ADDR, BYTE1, BYTE2 or any ACK state: -> IDLE, set error[1], no strobe, SDAT released that cycle.
  - Repeated START in any non-IDLE state: -> ADDR, bit counter cleared, shadows discarded, set error[1] unless the state was WAIT_STOP or IGNORE.
- busy drops the cycle STOP is detected.
- ACK timing: the ACK must be low before the initiator's 9th SDCLK rising edge. Required latency is at most 2+FILTER_LEN+2 clk after the SDCLK falling edge, which is well inside the initiator's ~400-clk low phase.
- SDAT is assigned 1'b0 when ack_drive=1, else 1'bz. There is no other drive path.

Test Plan:
- Initiator writes address 0x1A, rw=0, reg 0x04, data 0x012 -> three ACK slots low; wr_valid pulses once with wr_reg=7'h04, wr_data=9'h012; busy falls at STOP; error=0.
- Address 0x1B, write -> SDAT never driven low, initiator reports address NACK, no wr_valid, busy returns 0 at STOP.
- Address 0x1A with rw=1 -> NACK, state IGNORE, no wr_valid; a following valid write frame is accepted normally.
- rst pulled low during BYTE2 while the ACK is driven -> SDAT z within the same cycle, outputs return to reset values, no wr_valid; the next full frame produces wr_reg/wr_data correctly.
- Repeated START after BYTE1, then a full frame reg 0x07, data 0x1FF -> exactly one wr_valid, carrying 7'h07 and 9'h1FF; error[1]=1.
- SDCLK glitch of FILTER_LEN-1 clk during a bit, plus a 4th data byte before STOP -> the glitch causes no extra bit; the frame is still decoded; the 4th byte is NACKed; error[0]=1.

Source files
------------

// File: rtl/i2c_target.sv
// Write-only I2C target: receives address/register/data frames, ACKs its own
// write address open-drain and strobes the decoded 7-bit register / 9-bit data.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SDCLK,
  inout  wire        SDAT,
  output logic       wr_valid,
  output logic [6:0] wr_reg,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic [1:0] error
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP, IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [1:0]  raw, s1_q, s2_q, f_q;
  logic [3:0]  fcnt_q [2];
  logic        scl_p_q, sda_p_q;
  logic [6:0]  shift_q;
  logic [3:0]  bitcnt_q;
  logic [6:0]  reg_sh_q;
  logic        dat8_q;
  logic        wr_valid_q;
  logic [6:0]  wr_reg_q;
  logic [8:0]  wr_data_q;
  logic [1:0]  err_q;
  logic        sda_low;

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic sampling, bit_edge, byte_done, abort;
  logic [7:0] byte_w;

  assign raw = {SDAT, SDCLK};

  // Index 0 = SDCLK, index 1 = SDAT; a level is accepted after FILTER_LEN stable cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '1;
      s2_q      <= '1;
      f_q       <= '1;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
          f_q[i]    <= s2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign scl_f     = f_q[0];
  assign sda_f     = f_q[1];
  assign scl_rise  = scl_f & ~scl_p_q;
  assign scl_fall  = ~scl_f & scl_p_q;
  assign start_det = scl_f & sda_p_q & ~sda_f;
  assign stop_det  = scl_f & ~sda_p_q & sda_f;
  assign sampling  = state_q inside {ADDR, BYTE1, BYTE2, WAIT_STOP};
  assign bit_edge  = scl_rise & sampling & ~start_det & ~stop_det;
  assign byte_done = bit_edge & (bitcnt_q == 4'd7);
  assign byte_w    = {shift_q, sda_f};
  assign abort     = (start_det & !(state_q inside {IDLE, WAIT_STOP, IGNORE})) |
                     (stop_det & (state_q inside {ADDR, BYTE1, BYTE2, ACK_A, ACK_1, ACK_2}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // In ACK states ack_q doubles as the phase: first falling edge drives, second releases
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    if (start_det) begin
      state_d = ADDR;
      ack_d   = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR:  if (byte_done) state_d = (byte_w == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
        BYTE1: if (byte_done) state_d = ACK_1;
        BYTE2: if (byte_done) state_d = ACK_2;
        ACK_A, ACK_1, ACK_2: begin
          if (scl_fall) begin
            ack_d = ~ack_q;
            if (ack_q) begin
              state_d = (state_q == ACK_A) ? BYTE1 : (state_q == ACK_1) ? BYTE2 : WAIT_STOP;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_low = ack_q & ~start_det & ~stop_det;
    busy    = (state_q != IDLE) & ~stop_det;
  end

  assign SDAT = sda_low ? 1'b0 : 1'bz;

  // WAIT_STOP counts 9 clocks per byte so extra bytes stay aligned with their NACK slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      reg_sh_q   <= '0;
      dat8_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      err_q      <= '0;
    end else begin
      scl_p_q    <= scl_f;
      sda_p_q    <= sda_f;
      wr_valid_q <= 1'b0;
      if (start_det || stop_det || (state_d != state_q)) begin
        bitcnt_q <= '0;
      end else if (bit_edge) begin
        bitcnt_q <= (bitcnt_q == 4'd8) ? 4'd0 : bitcnt_q + 4'd1;
      end
      if (bit_edge) shift_q <= byte_w[6:0];
      if (start_det) begin
        reg_sh_q <= '0;
        dat8_q   <= 1'b0;
      end else if (byte_done && (state_q == BYTE1)) begin
        reg_sh_q <= byte_w[7:1];
        dat8_q   <= byte_w[0];
      end
      if (byte_done && (state_q == BYTE2)) begin
        wr_valid_q <= 1'b1;
        wr_reg_q   <= reg_sh_q;
        wr_data_q  <= {dat8_q, byte_w};
      end
      if (byte_done && (state_q == WAIT_STOP)) err_q[0] <= 1'b1;
      if (abort) err_q[1] <= 1'b1;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_reg   = wr_reg_q;
  assign wr_data  = wr_data_q;
  assign error    = err_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged initiator with random frames checked
// against a frame-level model (expected ACKs, write queue, sticky errors).
module tb_i2c_target;
  localparam logic [6:0] DEV = 7'h1A;
  localparam int FL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  SDAT;
  logic wr_valid, busy;
  logic [6:0] wr_reg;
  logic [8:0] wr_data;
  logic [1:0] error;

  int passed = 0;
  int total  = 0;

  logic [6:0]  m_reg = '0;
  logic [8:0]  m_data = '0;
  logic [1:0]  m_err = '0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  assign SDAT = m_sda ? 1'bz : 1'b0;
  pullup (SDAT);

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(DEV), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .SDCLK(m_scl), .SDAT(SDAT),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
    .busy(busy), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe contents come from the write queue; between strobes the outputs hold
  always @(negedge clk) begin
    if (rst) begin
      if (wr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(wr_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_reg", 32'(wr_reg), 32'(e[15:9]));
          check("wr_data", 32'(wr_data), 32'(e[8:0]));
          m_reg  = e[15:9];
          m_data = e[8:0];
        end
      end else begin
        check("hold_reg", 32'(wr_reg), 32'(m_reg));
        check("hold_data", 32'(wr_data), 32'(m_data));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: run did not finish");
    $fatal(1);
  end

  task automatic send_bit(input logic b, input bit glitch, input bit push, input logic [15:0] wr);
    wclk(8);
    m_sda = b;
    wclk(4);
    if (glitch) begin
      m_scl = 1'b1;
      wclk(FL - 1);
      m_scl = 1'b0;
    end else begin
      wclk(FL - 1);
    end
    wclk(6);
    if (push) exp_q.push_back(wr);
    m_scl = 1'b1;
    wclk(8);
    check("bus_bit", 32'(SDAT), 32'(b));
    wclk(8);
    m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit push,
                           input logic [15:0] wr, input int gbit);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == gbit, push && (i == 0), wr);
    wclk(8);
    m_sda = 1'b1;
    wclk(12);
    m_scl = 1'b1;
    wclk(8);
    check("ack_slot", 32'(SDAT), exp_ack ? 32'd0 : 32'd1);
    wclk(8);
    m_scl = 1'b0;
  endtask

  task automatic do_start();
    wclk(8);
    m_sda = 1'b1;
    wclk(8);
    m_scl = 1'b1;
    wclk(16);
    m_sda = 1'b0;
    wclk(16);
    m_scl = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("error_at_start", 32'(error), 32'(m_err));
  endtask

  task automatic do_stop();
    wclk(8);
    m_sda = 1'b0;
    wclk(12);
    m_scl = 1'b1;
    wclk(16);
    m_sda = 1'b1;
    wclk(16);
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  // Frame rules: only {DEV,0} is a write to us; bytes 0..2 ACKed, byte 2 commits,
  // a 4th byte is NACKed and flags overrun, ending before byte 2 flags an abort.
  task automatic do_frame(input logic [7:0] addr, input logic [6:0] rg, input logic [8:0] dt,
                          input int nbytes, input bit rstart_end, input int gbyte, input int gbit);
    logic [7:0] bytes [4];
    bit matched;
    matched  = (addr == {DEV, 1'b0});
    bytes[0] = addr;
    bytes[1] = {rg, dt[8]};
    bytes[2] = dt[7:0];
    bytes[3] = 8'($urandom);
    do_start();
    for (int i = 0; i < nbytes; i++)
      send_byte(bytes[i], matched && (i <= 2), matched && (i == 2), {rg, dt},
                (i == gbyte) ? gbit : -1);
    if (matched && nbytes >= 4) m_err[0] = 1'b1;
    if (matched && nbytes < 3) m_err[1] = 1'b1;
    if (!rstart_end) begin
      do_stop();
      check("error_after_stop", 32'(error), 32'(m_err));
      check("write_done", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    m_reg = '0;
    m_data = '0;
    m_err = '0;
    exp_q.delete();
    wclk(3);
    rst = 1'b1;
    wclk(3);
  endtask

  initial begin
    logic [7:0] addr;
    logic [6:0] a;
    int r, nb, q, gb;
    bit rs;

    #1;
    check("rst_sdat", 32'(SDAT), 32'd1);
    check("rst_valid", 32'(wr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_reg", 32'(wr_reg), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    wclk(3);
    rst = 1'b1;
    wclk(5);

    do_frame({DEV, 1'b0}, 7'h04, 9'h012, 3, 1'b0, -1, -1);
    check("t1_reg", 32'(wr_reg), 32'h04);
    check("t1_data", 32'(wr_data), 32'h012);
    check("t1_error", 32'(error), 32'd0);

    do_frame({7'h1B, 1'b0}, 7'h33, 9'h0AA, 3, 1'b0, -1, -1);
    do_frame({DEV, 1'b1}, 7'h35, 9'h0BB, 3, 1'b0, -1, -1);
    do_frame({DEV, 1'b0}, 7'h55, 9'h1C3, 3, 1'b0, -1, -1);
    check("t3_reg", 32'(wr_reg), 32'h55);

    do_start();
    send_byte({DEV, 1'b0}, 1'b1, 1'b0, '0, -1);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, 1'b0, 1'b0, '0);
    wclk(8);
    m_sda = 1'b1;
    wclk(8);
    check("ack_before_rst", 32'(SDAT), 32'd0);
    #3;
    rst = 1'b0;
    m_reg = '0;
    m_data = '0;
    m_err = '0;
    exp_q.delete();
    #1;
    check("rst_mid_sdat", 32'(SDAT), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(wr_valid), 32'd0);
    check("rst_mid_reg", 32'(wr_reg), 32'd0);
    check("rst_mid_data", 32'(wr_data), 32'd0);
    wclk(3);
    rst = 1'b1;
    do_stop();
    do_frame({DEV, 1'b0}, 7'h6C, 9'h0F0, 3, 1'b0, -1, -1);
    check("t4_reg", 32'(wr_reg), 32'h6C);
    check("t4_data", 32'(wr_data), 32'h0F0);

    do_frame({DEV, 1'b0}, 7'h11, 9'h155, 2, 1'b1, -1, -1);
    do_frame({DEV, 1'b0}, 7'h07, 9'h1FF, 3, 1'b0, -1, -1);
    check("t5_reg", 32'(wr_reg), 32'h07);
    check("t5_data", 32'(wr_data), 32'h1FF);
    check("t5_err1", 32'(error[1]), 32'd1);

    do_frame({DEV, 1'b0}, 7'h2A, 9'h155, 4, 1'b0, 1, 3);
    check("t6_reg", 32'(wr_reg), 32'h2A);
    check("t6_data", 32'(wr_data), 32'h155);
    check("t6_err0", 32'(error[0]), 32'd1);

    pulse_reset();
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        addr = {DEV, 1'b0};
      end else if (r < 85) begin
        a = 7'($urandom_range(0, 127));
        if (a == DEV) a = a + 7'd1;
        addr = {a, 1'b0};
      end else begin
        addr = {DEV, 1'b1};
      end
      q  = $urandom_range(0, 9);
      nb = (q < 1) ? 1 : (q < 2) ? 2 : (q < 8) ? 3 : 4;
      rs = ($urandom_range(0, 4) == 0) && (k != 29);
      gb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      do_frame(addr, 7'($urandom), 9'($urandom), nb, rs, gb, $urandom_range(0, 7));
    end
    wclk(20);
    check("final_error", 32'(error), 32'(m_err));
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
